inst_fetch: RTL

- Instruction fetch unit: the requesting side of the instruction ROM read interface.
- Owns the program counter and drives the ROM address. Samples the combinational ROM data into a one-entry instruction register.
- Presents the instruction to decode through a valid/ready handshake.
- Handles branch redirects, halt detection, and a delivered-instruction counter.

---
 rtl/inst_fetch.sv | 89 ++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction ROM,
// and hands one instruction at a time to decode over a valid/ready handshake.
module inst_fetch #(
    parameter int              ADDR_W     = 7,
    parameter int              DATA_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [DATA_W-1:0] HALT_INST  = 8'hFF,
    parameter int              CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              branch_en_i,
    input  logic              branch_rel_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              halted_o,
    output logic [CNT_W-1:0]  fetch_count_o
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [DATA_W-1:0] inst_reg;
    logic [ADDR_W-1:0] inst_addr_reg;
    logic              inst_valid_reg;
    logic              halted_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              fire;
    logic              load;
    logic [ADDR_W-1:0] branch_dest;

    assign fire = inst_valid_reg & inst_ready_i;
    // Branch pre-empts any load in the same cycle.
    assign load = (state_reg == RUN) && (!inst_valid_reg || fire) && !branch_en_i;
    assign branch_dest = branch_rel_i ? (inst_addr_reg + branch_target_i) : branch_target_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg      <= RUN;
            pc_reg         <= START_ADDR;
            inst_reg       <= '0;
            inst_addr_reg  <= '0;
            inst_valid_reg <= 1'b0;
            halted_reg     <= 1'b0;
            count_reg      <= '0;
        end else begin
            if (fire && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + 1'b1;
            end

            if (branch_en_i) begin
                pc_reg         <= branch_dest;
                inst_valid_reg <= 1'b0;
                state_reg      <= RUN;
                halted_reg     <= 1'b0;
            end else if (load) begin
                inst_reg       <= rom_data_i;
                inst_addr_reg  <= pc_reg;
                inst_valid_reg <= 1'b1;
                pc_reg         <= pc_reg + 1'b1;
                // The halt word is still delivered; only further loads stop.
                if (rom_data_i == HALT_INST) begin
                    state_reg  <= HALTED;
                    halted_reg <= 1'b1;
                end
            end else if (fire) begin
                inst_valid_reg <= 1'b0;
            end
        end
    end

    assign rom_addr_o    = pc_reg;
    assign inst_o        = inst_reg;
    assign inst_addr_o   = inst_addr_reg;
    assign inst_valid_o  = inst_valid_reg;
    assign halted_o      = halted_reg;
    assign fetch_count_o = count_reg;

endmodule
